// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates instruction and data requests onto one shared
// single-port RAM. Data accesses win ties, but a streak counter forces an
// instruction grant after MAX_D_STREAK data grants in a row while iREN waits.
// A watchdog bounds each RAM access and raises a sticky mem_err flag.
module memory_arbiter #(
    parameter int TIMEOUT      = 64,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [1:0]    RAM_ACCESS = 2'd2;
    localparam logic [1:0]    RAM_ERROR  = 2'd3;
    localparam logic [31:0]   BAD_LOAD   = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {
        IDLE,
        D_ACC,
        I_ACC,
        RESP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [SW-1:0] streak;

    logic data_req;
    logic force_i;
    logic grant_d;
    logic grant_i;

    // An instruction request that has watched MAX_D_STREAK data grants go by
    // takes priority over data for exactly one grant.
    assign data_req = dREN | dWEN;
    assign force_i  = iREN && (streak == STREAK_MAX);
    assign grant_d  = data_req && !force_i;
    assign grant_i  = iREN && !grant_d;

    // Arbiter FSM; every output is a register. ramREN/ramWEN double as the
    // latched operation of the access in flight, so a write never loads data.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            timer    <= '0;
            streak   <= '0;
            iload    <= '0;
            dload    <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ihit <= 1'b0;
                    dhit <= 1'b0;
                    if (grant_d) begin
                        state    <= D_ACC;
                        timer    <= '0;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        ramWEN   <= dWEN;
                        ramREN   <= !dWEN;
                        if (!iREN) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (grant_i) begin
                        state    <= I_ACC;
                        timer    <= '0;
                        ramaddr  <= iaddr;
                        ramstore <= '0;
                        ramWEN   <= 1'b0;
                        ramREN   <= 1'b1;
                        streak   <= '0;
                    end
                end
                D_ACC, I_ACC: begin
                    timer <= timer + TW'(1);
                    if (ramstate == RAM_ACCESS) begin
                        if (!ramWEN) begin
                            if (state == D_ACC) begin
                                dload <= ramload;
                            end else begin
                                iload <= ramload;
                            end
                        end
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        dhit   <= (state == D_ACC);
                        ihit   <= (state == I_ACC);
                        state  <= RESP;
                    end else if (ramstate == RAM_ERROR || timer == TIMER_LAST) begin
                        mem_err <= 1'b1;
                        if (state == D_ACC) begin
                            dload <= BAD_LOAD;
                        end else begin
                            iload <= BAD_LOAD;
                        end
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        dhit   <= (state == D_ACC);
                        ihit   <= (state == I_ACC);
                        state  <= RESP;
                    end
                end
                RESP: begin
                    ihit  <= 1'b0;
                    dhit  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table-driven single transactions, hand-written corner
// sequences (streak fairness, async reset mid-access) and a randomized run,
// all cross-checked every cycle against a transaction-level reference model.
module tb_memory_arbiter;

    localparam int TIMEOUT      = 8;
    localparam int MAX_D_STREAK = 4;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        mem_err;

    int check_count = 0;
    int pass_count  = 0;

    memory_arbiter #(
        .TIMEOUT      (TIMEOUT),
        .MAX_D_STREAK (MAX_D_STREAK)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: one outstanding transaction, tracked by how many RAM
    // cycles it has spent, plus a count of consecutive data wins over iREN.
    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          age;
    } txn_t;

    int          m_phase;
    txn_t        m_txn;
    int          m_streak;
    bit          m_err;
    bit          m_ihit;
    bit          m_dhit;
    logic [31:0] m_iload;
    logic [31:0] m_dload;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_txn.is_d  = 0;
        m_txn.wr    = 0;
        m_txn.addr  = '0;
        m_txn.data  = '0;
        m_txn.age   = 0;
        m_streak    = 0;
        m_err       = 0;
        m_ihit      = 0;
        m_dhit      = 0;
        m_iload     = '0;
        m_dload     = '0;
    endtask

    // Advance the model across one rising edge using the inputs as they stand.
    task automatic model_edge();
        bit          want_d;
        bit          starved;
        bit          bad;
        logic [31:0] val;
        m_ihit = 0;
        m_dhit = 0;
        if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_txn.age++;
            if (ramstate == RS_ACCESS || ramstate == RS_ERROR || m_txn.age >= TIMEOUT) begin
                bad = (ramstate != RS_ACCESS);
                if (bad) m_err = 1;
                if (bad || !m_txn.wr) begin
                    val = bad ? 32'hBAD1_BAD1 : ramload;
                    if (m_txn.is_d) m_dload = val;
                    else m_iload = val;
                end
                if (m_txn.is_d) m_dhit = 1;
                else m_ihit = 1;
                m_phase = 2;
            end
        end else begin
            want_d  = dREN | dWEN;
            starved = iREN && (m_streak >= MAX_D_STREAK);
            if (want_d && !starved) begin
                m_txn.is_d = 1;
                m_txn.wr   = dWEN;
                m_txn.addr = daddr;
                m_txn.data = dstore;
                m_txn.age  = 0;
                m_streak   = iREN ? ((m_streak < MAX_D_STREAK) ? m_streak + 1 : MAX_D_STREAK) : 0;
                m_phase    = 1;
            end else if (iREN) begin
                m_txn.is_d = 0;
                m_txn.wr   = 0;
                m_txn.addr = iaddr;
                m_txn.data = '0;
                m_txn.age  = 0;
                m_streak   = 0;
                m_phase    = 1;
            end
        end
    endtask

    task automatic checkOutput();
        check("ihit", 32'(ihit), 32'(m_ihit));
        check("dhit", 32'(dhit), 32'(m_dhit));
        check("hit_overlap", 32'(ihit & dhit), 32'd0);
        check("ramREN", 32'(ramREN), 32'(m_phase == 1 && !m_txn.wr));
        check("ramWEN", 32'(ramWEN), 32'(m_phase == 1 && m_txn.wr));
        check("mem_err", 32'(mem_err), 32'(m_err));
        check("iload", iload, m_iload);
        check("dload", dload, m_dload);
        if (m_phase == 1) check("ramaddr", ramaddr, m_txn.addr);
        if (m_phase == 1 && m_txn.wr) check("ramstore", ramstore, m_txn.data);
    endtask

    task automatic applyStimulus();
        model_edge();
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    task automatic drop_requests();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ramstate = RS_FREE;
    endtask

    // One transaction described by a table row: ramstate is BUSY for the
    // first `busy` access cycles, then final_st. Latency counts edges from
    // the grant edge (1) to the edge that raises the hit.
    typedef struct {
        bit          is_i;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rload;
        int          busy;
        logic [1:0]  final_st;
        int          exp_lat;
        logic [31:0] exp_load;
        bit          exp_err;
    } row_t;

    row_t rows[8];

    task automatic run_row(input row_t r, input int idx);
        int lat;
        bit seen;
        bit hit_i;
        lat   = 0;
        seen  = 0;
        hit_i = 0;
        iREN     = r.is_i;
        iaddr    = r.is_i ? r.addr : 32'h0;
        dREN     = r.ren;
        dWEN     = r.wen;
        daddr    = r.is_i ? 32'h0 : r.addr;
        dstore   = r.store;
        ramload  = r.rload;
        ramstate = RS_FREE;
        for (int k = 1; k <= 40 && !seen; k++) begin
            applyStimulus();
            if (ihit || dhit) begin
                seen  = 1;
                lat   = k;
                hit_i = ihit;
            end else begin
                ramstate = (k <= r.busy) ? RS_BUSY : r.final_st;
            end
        end
        drop_requests();
        check($sformatf("row%0d_latency", idx), 32'(lat), 32'(r.exp_lat));
        check($sformatf("row%0d_hit_port", idx), 32'(hit_i), 32'(r.is_i));
        check($sformatf("row%0d_load", idx), r.is_i ? iload : dload, r.exp_load);
        check($sformatf("row%0d_mem_err", idx), 32'(mem_err), 32'(r.exp_err));
        applyStimulus();
    endtask

    initial begin
        bit exp_order[10];
        bit got_order[10];
        int nhits;
        int r;

        rows[0] = '{1, 0, 0, 32'h40,  32'h0,         32'h2408_0001, 0,   RS_ACCESS, 2, 32'h2408_0001, 0};
        rows[1] = '{0, 1, 0, 32'h100, 32'h0,         32'hCAFE_F00D, 1,   RS_ACCESS, 3, 32'hCAFE_F00D, 0};
        rows[2] = '{0, 0, 1, 32'h80,  32'hDEAD_BEEF, 32'h1111_1111, 3,   RS_ACCESS, 5, 32'hCAFE_F00D, 0};
        rows[3] = '{0, 1, 1, 32'h84,  32'h1234_5678, 32'h2222_2222, 0,   RS_ACCESS, 2, 32'hCAFE_F00D, 0};
        rows[4] = '{1, 0, 0, 32'h44,  32'h0,         32'h0BAD_F00D, 2,   RS_ACCESS, 4, 32'h0BAD_F00D, 0};
        rows[5] = '{1, 0, 0, 32'h48,  32'h0,         32'h3333_3333, 1,   RS_ERROR,  3, 32'hBAD1_BAD1, 1};
        rows[6] = '{0, 1, 0, 32'h200, 32'h0,         32'h5555_5555, 100, RS_BUSY,   9, 32'hBAD1_BAD1, 1};
        rows[7] = '{0, 1, 0, 32'h204, 32'h0,         32'h4444_4444, 0,   RS_ACCESS, 2, 32'h4444_4444, 1};
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        nRST = 1'b0;
        iaddr = '0;
        daddr = '0;
        dstore = '0;
        ramload = '0;
        drop_requests();
        model_reset();
        @(posedge CLK);
        #1;
        checkOutput();
        nRST = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_row(rows[i], i);
        end

        // Async reset while a write is in flight: everything clears at once,
        // including the sticky error left behind by the earlier rows.
        dWEN     = 1'b1;
        daddr    = 32'h80;
        dstore   = 32'hDEAD_BEEF;
        ramstate = RS_BUSY;
        applyStimulus();
        applyStimulus();
        check("pre_reset_ramWEN", 32'(ramWEN), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check("reset_ramWEN", 32'(ramWEN), 32'd0);
        check("reset_dhit", 32'(dhit), 32'd0);
        check("reset_mem_err", 32'(mem_err), 32'd0);
        check("reset_ramREN", 32'(ramREN), 32'd0);
        drop_requests();
        @(posedge CLK);
        #1;
        checkOutput();
        nRST = 1'b1;
        run_row(rows[0], 8);

        // Both ports requesting continuously: data wins four, then one I.
        iREN     = 1'b1;
        dREN     = 1'b1;
        iaddr    = 32'h400;
        daddr    = 32'h800;
        ramload  = 32'h7777_0000;
        ramstate = RS_ACCESS;
        nhits    = 0;
        for (int k = 0; k < 60 && nhits < 10; k++) begin
            applyStimulus();
            if (ihit || dhit) begin
                got_order[nhits] = ihit;
                nhits++;
            end
        end
        check("streak_hits_seen", 32'(nhits), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("grant_order_%0d", i), 32'(got_order[i]), 32'(exp_order[i]));
        end
        drop_requests();
        applyStimulus();
        applyStimulus();

        // Random traffic and RAM behaviour against the model.
        for (int k = 0; k < 3000; k++) begin
            iREN    = ($urandom_range(0, 2) != 0);
            dREN    = ($urandom_range(0, 1) != 0);
            dWEN    = ($urandom_range(0, 3) == 0);
            iaddr   = $urandom;
            daddr   = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 19);
            if (r < 8)       ramstate = RS_BUSY;
            else if (r < 17) ramstate = RS_ACCESS;
            else if (r < 18) ramstate = RS_ERROR;
            else             ramstate = RS_FREE;
            applyStimulus();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
